// File: rtl/wta_pkg.sv
// Shared types and helpers for the k-winner-take-all stage.
package wta_pkg;

  localparam int unsigned MaxLines = 1024;
  localparam int unsigned SelW     = $clog2(MaxLines + 1);

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  typedef struct packed {
    logic [SelW-1:0]     count;
    logic [MaxLines-1:0] picked;
  } sel_t;

  // Keep at most budget set bits of vec, lowest index first.
  function automatic sel_t popcount_lim(input logic [MaxLines-1:0] vec,
                                        input logic [SelW-1:0]     budget);
    sel_t r;
    r = '0;
    for (int i = 0; i < MaxLines; i++) begin
      if (vec[i] && (r.count < budget)) begin
        r.picked[i] = 1'b1;
        r.count     = r.count + SelW'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wta_kselect.sv
// Combinational lowest-index-first selector of up to budget set bits.
module wta_kselect
  import wta_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned BW = 2
) (
  input  logic [N-1:0]  vec,
  input  logic [BW-1:0] budget,
  output logic [N-1:0]  picked,
  output logic [BW-1:0] count
);

  logic [MaxLines-1:0] vec_ext;
  logic [SelW-1:0]     budget_ext;
  sel_t                sel;
  logic                unused_sel;

  always_comb begin
    vec_ext             = '0;
    vec_ext[N-1:0]      = vec;
    budget_ext          = '0;
    budget_ext[BW-1:0]  = budget;
    sel                 = popcount_lim(vec_ext, budget_ext);
    picked              = sel.picked[N-1:0];
    // count never exceeds budget, so the narrow slice is exact.
    count               = sel.count[BW-1:0];
  end

  assign unused_sel = ^sel;

endmodule

// File: rtl/wta_k.sv
// k-winner-take-all stage: first K rising spike lines per gamma cycle get a
// fixed-width output pulse; all other lines are suppressed.
module wta_k
  import wta_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned NUM_INPUTS        = 128,
  parameter int unsigned K                 = 1
) (
  input  logic                       aclk,
  input  logic                       rst,
  input  logic [NUM_INPUTS-1:0]      input_spikes,
  output logic [NUM_INPUTS-1:0]      output_spikes,
  output logic                       gamma_start,
  output logic [$clog2(K+1)-1:0]     winner_count
);

  localparam int unsigned GW = cnt_width(GAMMA_CYCLE_WIDTH - 1);
  localparam int unsigned PW = cnt_width(PULSE_WIDTH);
  localparam int unsigned KW = $clog2(K + 1);

  localparam logic [GW-1:0] GLast = GW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [PW-1:0] PLoad = PW'(PULSE_WIDTH);
  localparam logic [KW-1:0] KMax  = KW'(K);

  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic [NUM_INPUTS-1:0] prev_q;
  logic [NUM_INPUTS-1:0] mask_q, mask_d;
  logic [KW-1:0]         wcnt_q, wcnt_d;
  logic [PW-1:0]         cnt_q [NUM_INPUTS];
  logic [PW-1:0]         cnt_d [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] out_q, out_d;

  logic [NUM_INPUTS-1:0] edges;
  logic [NUM_INPUTS-1:0] picked;
  logic [KW-1:0]         npick;
  logic [KW-1:0]         budget;
  logic                  wrap;

  assign edges  = input_spikes & ~prev_q & ~mask_q;
  assign budget = KMax - wcnt_q;
  assign wrap   = (gcnt_q == GLast);

  wta_kselect #(
    .N  (NUM_INPUTS),
    .BW (KW)
  ) u_kselect (
    .vec    (edges),
    .budget (budget),
    .picked (picked),
    .count  (npick)
  );

  always_comb begin
    gcnt_d = wrap ? '0 : gcnt_q + GW'(1);
    // Picks in the last gamma count still fire but don't charge the new cycle.
    if (wrap) begin
      mask_d = '0;
      wcnt_d = '0;
    end else begin
      mask_d = mask_q | picked;
      wcnt_d = wcnt_q + npick;
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (picked[i]) begin
        cnt_d[i] = PLoad;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - PW'(1);
      end
      out_d[i] = (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      gcnt_q <= '0;
      prev_q <= '0;
      mask_q <= '0;
      wcnt_q <= '0;
      cnt_q  <= '{default: '0};
      out_q  <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      prev_q <= input_spikes;
      mask_q <= mask_d;
      wcnt_q <= wcnt_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign output_spikes = out_q;
  assign gamma_start   = (gcnt_q == '0);
  assign winner_count  = wcnt_q;

endmodule

// File: doc/wta_k.md
# wta_k

Parametrised k-winner-take-all stage for the spiking column datapath. It generalises the single-winner WTA to up to K winners per gamma cycle. The stage watches NUM_INPUTS spike lines and selects the first K lines to rise within each gamma cycle, breaking ties by lowest index. It emits a fixed-width output pulse on each winning line and suppresses all other lines.

## Interface
- GAMMA_CYCLE_WIDTH, 16, clocks per gamma cycle; must be ≥ 2.
- PULSE_WIDTH, 8, output pulse length in clocks; must satisfy 1 ≤ PULSE_WIDTH ≤ GAMMA_CYCLE_WIDTH.
- NUM_INPUTS, 128, number of spike lines.
- K, 1, maximum winners per gamma cycle; must satisfy 1 ≤ K ≤ NUM_INPUTS.

Ports (clock and reset first):
- aclk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- input_spikes  in  NUM_INPUTS  spike lines; a spike is a 0→1 transition.
- output_spikes  out  NUM_INPUTS  winner pulses; registered.
- gamma_start  out  1  high during gamma count 0; registered.
- winner_count  out  $clog2(K+1)  winners so far in the current gamma cycle; registered.

## Operation
- Gamma counter gcnt:
  - Counts 0..GAMMA_CYCLE_WIDTH-1, then wraps to 0.
  - gamma_start = (gcnt == 0), decoded from the register only.
- Edge detect:
  - prev_in register holds last cycle's input_spikes.
  - edges = input_spikes & ~prev_in & ~win_mask.
- Winner selection, each cycle:
  - budget = K − winner_count.
  - Pick up to budget set bits of edges, lowest index first.
  - Set the picked bits in win_mask.
  - Add the number picked to winner_count.
- Pulse generation:
  - Each line has a down-counter of width $clog2(PULSE_WIDTH+1).
  - A picked line loads PULSE_WIDTH. This includes a line still pulsing from the previous gamma cycle: the pulse extends and is not OR'd.
  - A nonzero counter decrements by 1 per cycle.
  - output_spikes[i] = (cnt[i] != 0), registered.
- Gamma wrap: in the cycle where gcnt == GAMMA_CYCLE_WIDTH-1, the next state has win_mask = 0 and winner_count = 0.
  - Picks made in that same cycle still load their pulse counters.
  - Those picks do not carry into the new cycle's count or mask.
- A line that already won cannot win again in the same gamma cycle. Its later rising edges are ignored.
- Edges arriving after the budget is exhausted are dropped; they are not queued.
- Pulses are never truncated by a gamma wrap.

## Timing
- Reset values:
  - output_spikes = 0.
  - gamma_start = 1 (gcnt = 0).
  - winner_count = 0.
  - prev_in, win_mask and all pulse counters = 0.
- Input high at the first edge after reset: counts as a rising edge.
- Latency: input rises and is sampled at edge n. The output goes high after edge n+1 and stays high for exactly PULSE_WIDTH cycles.
- Simultaneous edges exceeding the budget: the lowest indices win and the rest are dropped.
- Reset mid-pulse: outputs drop to 0 asynchronously. The gamma cycle restarts at count 0.
- No combinational path from input_spikes to any output.

## Structure
- wta_pkg holds:
  - a localparam helper for counter widths;
  - function popcount_lim(vec, budget), which returns the count and the masked vector.
- Sub-module wta_kselect: combinational lowest-index-first selector of up to budget bits from an N-bit vector.
- wta_k contains all state: gcnt, prev_in, win_mask, winner_count and the pulse counters. Estimated 200–300 lines total.

## Test plan
All scenarios use NUM_INPUTS = 8, K = 2, GAMMA_CYCLE_WIDTH = 16, PULSE_WIDTH = 4.
- Single spike: bit 5 rises at gcnt = 3 → output_spikes = 8'h20 for 4 cycles starting 1 cycle later; winner_count = 1.
- Tie: bits 1, 4 and 6 rise together at gcnt = 2 → bits 1 and 4 pulse, bit 6 stays low; winner_count = 2.
- Budget exhausted: bit 3 rises at gcnt = 1, bit 0 at gcnt = 5, bit 7 at gcnt = 9 → only bits 3 and 0 pulse.
- Re-fire: bit 2 pulses at gcnt = 1, falls, then rises again at gcnt = 8 → no second pulse in that gamma cycle.
- Wrap boundary:
  - bit 6 rises at gcnt = 15 → it pulses across the wrap, and winner_count reads 0 at gcnt = 0;
  - two new lines rising at gcnt = 1 → both win.
- Reset mid-pulse: assert rst during an active pulse → all outputs go to 0 immediately; after release, gamma_start = 1 and winner_count = 0.
